// File: rtl/sub_ctrl_defs.sv
// rtl/sub_ctrl_defs.sv - shared state encodings for serial arithmetic controllers
package sub_ctrl_defs;

    localparam logic [1:0] SUB_IDLE  = 2'd0;
    localparam logic [1:0] SUB_SHIFT = 2'd1;
    localparam logic [1:0] SUB_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = SUB_IDLE,
        SHIFT = SUB_SHIFT,
        DONE  = SUB_DONE
    } sub_state_t;

endpackage

// File: rtl/full_sub_cell.sv
// rtl/full_sub_cell.sv - one-bit full subtractor from two half-subtractor stages
module full_sub_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_d1;
    logic w_b1;
    logic w_b2;

    assign w_d1 = x ^ y;
    assign w_b1 = ~x & y;
    assign d    = w_d1 ^ bin;
    assign w_b2 = ~w_d1 & bin;
    assign bout = w_b1 | w_b2;

endmodule

// File: rtl/bit_serial_subtractor.sv
// rtl/bit_serial_subtractor.sv - LSB-first serial a-b, one bit per SHIFT cycle
module bit_serial_subtractor
    import sub_ctrl_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sub_state_t       r_state;
    sub_state_t       w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_br;
    logic             r_borrow;
    logic             r_done;
    logic             w_d;
    logic             w_bo;
    logic [WIDTH-1:0] w_res_next;

    full_sub_cell u_cell (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bo)
    );

    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_next = w_d;
        end else begin : g_res_wn
            assign w_res_next = {w_d, r_res[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (r_cnt == LAST) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // done is registered on the DONE->IDLE edge; diff/borrow are already valid then
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_br     <= 1'b0;
            r_borrow <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_br  <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_next;
                    r_br  <= w_bo;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_diff   <= w_res_next;
                        r_borrow <= w_bo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != IDLE);
    assign done   = r_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// tb/tb_bit_serial_subtractor.sv - randomized and directed checks of bit_serial_subtractor
module tb_bit_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       borrow1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_serial_subtractor #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow)
    );

    bit_serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
    );

    // Launch one operation, scramble operands after accept, observe 20 cycles.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, output int lat,
                         output int ndone, output logic [7:0] od, output logic ob);
        @(negedge clk);
        a = ta; b = tb_; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom);
        lat = -1; ndone = 0; od = 8'h00; ob = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if (done) begin
                if (lat < 0) begin lat = k; od = diff; ob = borrow; end
                ndone++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        a = 8'h00; b = 8'h00; a1 = 1'b0; b1 = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (diff !== 8'h00)  begin errors++; $display("FAIL reset_diff got %h want 00", diff); end
        checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow got %b want 0", borrow); end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [7:0] ta[3] = '{8'h35, 8'h00, 8'hAA};
        logic [7:0] tb_[3] = '{8'h12, 8'h01, 8'hAA};
        logic [7:0] ed[3] = '{8'h23, 8'hFF, 8'h00};
        logic       eb[3] = '{1'b0, 1'b1, 1'b0};
        int lat, nd; logic [7:0] od; logic ob;
        for (int i = 0; i < 3; i++) begin
            do_op(ta[i], tb_[i], lat, nd, od, ob);
            checks++; if (lat !== 9)   begin errors++; $display("FAIL dir%0d_latency got %0d want 9", i, lat); end
            checks++; if (nd !== 1)    begin errors++; $display("FAIL dir%0d_ndone got %0d want 1", i, nd); end
            checks++; if (od !== ed[i]) begin errors++; $display("FAIL dir%0d_diff got %h want %h", i, od, ed[i]); end
            checks++; if (ob !== eb[i]) begin errors++; $display("FAIL dir%0d_borrow got %b want %b", i, ob, eb[i]); end
        end
    endtask

    task automatic test_random;
        int lat, nd, dd; logic [7:0] od, ta, tb_, ed; logic ob, eb;
        for (int i = 0; i < 25; i++) begin
            ta = 8'($urandom); tb_ = 8'($urandom);
            dd = int'(ta) - int'(tb_);
            ed = dd[7:0]; eb = (dd < 0);
            do_op(ta, tb_, lat, nd, od, ob);
            checks++; if (lat !== 9) begin errors++; $display("FAIL rnd%0d_latency got %0d want 9", i, lat); end
            checks++; if (od !== ed) begin errors++; $display("FAIL rnd%0d_diff a=%h b=%h got %h want %h", i, ta, tb_, od, ed); end
            checks++; if (ob !== eb) begin errors++; $display("FAIL rnd%0d_borrow a=%h b=%h got %b want %b", i, ta, tb_, ob, eb); end
        end
    endtask

    task automatic test_ignore_start;
        int nd = 0, busy_bad = 0; logic [7:0] od = 8'h00; logic ob = 1'b1;
        @(negedge clk);
        a = 8'h35; b = 8'h12; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 3) begin a = 8'h01; b = 8'h01; start = 1'b1; end
            if (k == 4) start = 1'b0;
            if (k <= 8 && !busy) busy_bad++;
            if (done) begin nd++; od = diff; ob = borrow; end
        end
        checks++; if (busy_bad !== 0) begin errors++; $display("FAIL ign_busy_gaps got %0d want 0", busy_bad); end
        checks++; if (nd !== 1)       begin errors++; $display("FAIL ign_ndone got %0d want 1", nd); end
        checks++; if (od !== 8'h23)   begin errors++; $display("FAIL ign_diff got %h want 23", od); end
        checks++; if (ob !== 1'b0)    begin errors++; $display("FAIL ign_borrow got %b want 0", ob); end
    endtask

    task automatic test_reset_mid;
        int nd = 0, lat; logic [7:0] od; logic ob;
        @(negedge clk);
        a = 8'hC3; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (diff !== 8'h23) begin errors++; $display("FAIL mid_hold_diff got %h want 23", diff); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        checks++; if (diff !== 8'h00)  begin errors++; $display("FAIL mid_rst_diff got %h want 00", diff); end
        checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL mid_rst_borrow got %b want 0", borrow); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL mid_aborted got %0d active cycles want 0", nd); end
        do_op(8'h10, 8'h20, lat, nd, od, ob);
        checks++; if (lat !== 9)   begin errors++; $display("FAIL mid_next_latency got %0d want 9", lat); end
        checks++; if (od !== 8'hF0) begin errors++; $display("FAIL mid_next_diff got %h want F0", od); end
        checks++; if (ob !== 1'b1) begin errors++; $display("FAIL mid_next_borrow got %b want 1", ob); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] opa[3], opb[3], ed;
        int acc[3] = '{0, 0, 0};
        int nacc = 0, nd = 0, dd;
        logic pb = 1'b0;
        for (int i = 0; i < 3; i++) begin opa[i] = 8'($urandom); opb[i] = 8'($urandom); end
        @(negedge clk);
        a = opa[0]; b = opb[0]; start = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (busy && !pb) begin
                if (nacc < 3) acc[nacc] = c;
                nacc++;
                a = 8'($urandom); b = 8'($urandom);
                if (nacc >= 3) start = 1'b0;
            end else if (nacc > 0 && nacc < 3 && c == acc[nacc-1] + 4) begin
                a = opa[nacc]; b = opb[nacc];
            end
            if (done) begin
                if (nd < 3) begin
                    dd = int'(opa[nd]) - int'(opb[nd]);
                    ed = dd[7:0];
                    checks++; if (diff !== ed) begin errors++; $display("FAIL b2b%0d_diff got %h want %h", nd, diff, ed); end
                    checks++; if (borrow !== (dd < 0)) begin errors++; $display("FAIL b2b%0d_borrow got %b want %b", nd, borrow, (dd < 0)); end
                end
                nd++;
            end
            pb = busy;
        end
        checks++; if (nacc !== 3) begin errors++; $display("FAIL b2b_accepts got %0d want 3", nacc); end
        checks++; if (acc[1] - acc[0] !== 10) begin errors++; $display("FAIL b2b_gap1 got %0d want 10", acc[1] - acc[0]); end
        checks++; if (acc[2] - acc[1] !== 10) begin errors++; $display("FAIL b2b_gap2 got %0d want 10", acc[2] - acc[1]); end
        checks++; if (nd !== 3) begin errors++; $display("FAIL b2b_ndone got %0d want 3", nd); end
    endtask

    task automatic test_width1;
        int lat, nd, dd; logic od, ob;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a1 = 1'(i >> 1); b1 = 1'(i); start1 = 1'b1;
            dd = int'(a1) - int'(b1);
            @(negedge clk);
            start1 = 1'b0; a1 = ~a1; b1 = ~b1;
            lat = -1; nd = 0; od = 1'b0; ob = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (k > 0) @(negedge clk);
                if (done1) begin
                    if (lat < 0) begin lat = k; od = diff1[0]; ob = borrow1; end
                    nd++;
                end
            end
            checks++; if (lat !== 2) begin errors++; $display("FAIL w1_%0d_latency got %0d want 2", i, lat); end
            checks++; if (nd !== 1)  begin errors++; $display("FAIL w1_%0d_ndone got %0d want 1", i, nd); end
            checks++; if (od !== dd[0]) begin errors++; $display("FAIL w1_%0d_diff got %b want %b", i, od, dd[0]); end
            checks++; if (ob !== (dd < 0)) begin errors++; $display("FAIL w1_%0d_borrow got %b want %b", i, ob, (dd < 0)); end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_ignore_start;
        test_reset_mid;
        test_back_to_back;
        test_width1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
